nmi_gen_multi: RTL and testbench

//  Parametrised NMI generator: N_ESC escalation-receiver channels, each with a differential esc/resp

---
 rtl/nmi_gen_multi_pkg.sv | 24 ++
 rtl/nmi_gen_multi_if.sv | 20 ++
 rtl/nmi_esc_rx_chan.sv | 83 ++++++++
 rtl/nmi_gen_multi.sv | 83 ++++++++
 tb/tb_nmi_gen_multi.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nmi_gen_multi_pkg.sv
// Shared types and constants for the multi-channel NMI generator.
package nmi_gen_multi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_PINGRESP = 3'd2,
        ST_ESCRESP  = 3'd3,
        ST_SIGINT   = 3'd4
    } esc_rx_state_e;

    localparam logic [2:0] ADDR_INTR_STATE    = 3'd0;
    localparam logic [2:0] ADDR_INTR_ENABLE   = 3'd1;
    localparam logic [2:0] ADDR_INTR_TEST     = 3'd2;
    localparam logic [2:0] ADDR_SIGINT_STATUS = 3'd3;
    localparam logic [2:0] ADDR_ESC_ACTIVE    = 3'd4;

    // {p,n} rail pairs for both the esc inputs and the resp outputs
    localparam logic [1:0] RAIL_LO   = 2'b01;
    localparam logic [1:0] RAIL_HI   = 2'b10;
    localparam logic [1:0] RAIL_BOTH = 2'b11;
    localparam logic [1:0] RAIL_NONE = 2'b00;

endpackage

// File: rtl/nmi_gen_multi_if.sv
// Simple register port of the NMI generator; master drives strobes, slave returns read data.
interface nmi_gen_multi_if #(
    parameter int unsigned DW = 32
);
    logic          reg_we_i;
    logic          reg_re_i;
    logic [2:0]    reg_addr_i;
    logic [DW-1:0] reg_wdata_i;
    logic [DW-1:0] reg_rdata_o;

    modport master (
        output reg_we_i, reg_re_i, reg_addr_i, reg_wdata_i,
        input  reg_rdata_o
    );

    modport slave (
        input  reg_we_i, reg_re_i, reg_addr_i, reg_wdata_i,
        output reg_rdata_o
    );
endinterface

// File: rtl/nmi_esc_rx_chan.sv
// One escalation receiver: differential esc/resp handshake FSM, registered esc_en and sigint-entry pulse.
// NMI_GEN_SIGINT_ESC_EN: when defined, the SIGINT state also asserts esc_en.
module nmi_esc_rx_chan
    import nmi_gen_multi_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_esc_p,
    input  logic i_esc_n,
    output logic o_resp_p,
    output logic o_resp_n,
    output logic o_esc_en,
    output logic o_sigint
);

    esc_rx_state_e r_state, w_state_nxt;
    logic          r_phase;
    logic          r_esc_en;
    logic          r_sigint;
    logic [1:0]    w_esc;
    logic [1:0]    w_resp;
    logic          w_esc_en;

    assign w_esc = {i_esc_p, i_esc_n};

    always_comb begin
        w_state_nxt = r_state;
        w_resp      = RAIL_LO;
        w_esc_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_esc == RAIL_HI)      w_state_nxt = ST_CHECK;
                else if (w_esc != RAIL_LO) w_state_nxt = ST_SIGINT;
            end
            ST_CHECK: begin
                w_resp = RAIL_HI;
                if (w_esc == RAIL_HI)      w_state_nxt = ST_ESCRESP;
                else if (w_esc == RAIL_LO) w_state_nxt = ST_PINGRESP;
                else                       w_state_nxt = ST_SIGINT;
            end
            ST_PINGRESP: begin
                w_state_nxt = ST_IDLE;
            end
            ST_ESCRESP: begin
                w_esc_en = 1'b1;
                w_resp   = r_phase ? RAIL_HI : RAIL_LO;
                if (w_esc == RAIL_LO)      w_state_nxt = ST_IDLE;
                else if (w_esc != RAIL_HI) w_state_nxt = ST_SIGINT;
            end
            ST_SIGINT: begin
                w_resp = r_phase ? RAIL_NONE : RAIL_BOTH;
`ifdef NMI_GEN_SIGINT_ESC_EN
                w_esc_en = 1'b1;
`else
                w_esc_en = 1'b0;
`endif
                if (w_esc == RAIL_LO) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // phase restarts on every state change so ESCRESP/SIGINT toggling always begins at 01/11
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_phase  <= 1'b0;
            r_esc_en <= 1'b0;
            r_sigint <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= (w_state_nxt == r_state) ? ~r_phase : 1'b0;
            r_esc_en <= w_esc_en;
            r_sigint <= (w_state_nxt == ST_SIGINT) && (r_state != ST_SIGINT);
        end
    end

    assign o_resp_p = w_resp[1];
    assign o_resp_n = w_resp[0];
    assign o_esc_en = r_esc_en;
    assign o_sigint = r_sigint;

endmodule

// File: rtl/nmi_gen_multi.sv
// NMI generator top: N_ESC escalation receivers, interrupt/status register file, OR-reduced nmi_o.
// NMI_GEN_SIGINT_ESC_EN (in nmi_esc_rx_chan): SIGINT also drives esc_en and thus raises an interrupt.
module nmi_gen_multi
    import nmi_gen_multi_pkg::*;
#(
    parameter int unsigned N_ESC = 4,
    parameter int unsigned DW    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    nmi_gen_multi_if.slave   reg_if,
    input  logic [N_ESC-1:0] esc_p_i,
    input  logic [N_ESC-1:0] esc_n_i,
    output logic [N_ESC-1:0] resp_p_o,
    output logic [N_ESC-1:0] resp_n_o,
    output logic [N_ESC-1:0] esc_en_o,
    output logic [N_ESC-1:0] intr_o,
    output logic             nmi_o
);

    logic [N_ESC-1:0] w_esc_en, w_sigint, w_wdata;
    logic [N_ESC-1:0] w_hw_set, w_test_set, w_state_clr, w_sig_clr;
    logic [N_ESC-1:0] r_esc_en_q, r_intr_state, r_intr_enable, r_sigint_status;
    logic [DW-1:0]    w_rd_val, r_rdata;
    logic             r_nmi;

    for (genvar k = 0; k < N_ESC; k++) begin : g_chan
        nmi_esc_rx_chan u_chan (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .i_esc_p  (esc_p_i[k]),
            .i_esc_n  (esc_n_i[k]),
            .o_resp_p (resp_p_o[k]),
            .o_resp_n (resp_n_o[k]),
            .o_esc_en (w_esc_en[k]),
            .o_sigint (w_sigint[k])
        );
    end

    assign w_wdata     = reg_if.reg_wdata_i[N_ESC-1:0];
    assign w_hw_set    = w_esc_en & ~r_esc_en_q;
    assign w_test_set  = (reg_if.reg_we_i && reg_if.reg_addr_i == ADDR_INTR_TEST)     ? w_wdata : '0;
    assign w_state_clr = (reg_if.reg_we_i && reg_if.reg_addr_i == ADDR_INTR_STATE)    ? w_wdata : '0;
    assign w_sig_clr   = (reg_if.reg_we_i && reg_if.reg_addr_i == ADDR_SIGINT_STATUS) ? w_wdata : '0;

    always_comb begin
        w_rd_val = '0;
        case (reg_if.reg_addr_i)
            ADDR_INTR_STATE:    w_rd_val[N_ESC-1:0] = r_intr_state;
            ADDR_INTR_ENABLE:   w_rd_val[N_ESC-1:0] = r_intr_enable;
            ADDR_SIGINT_STATUS: w_rd_val[N_ESC-1:0] = r_sigint_status;
            ADDR_ESC_ACTIVE:    w_rd_val[N_ESC-1:0] = w_esc_en;
            default:            w_rd_val = '0;
        endcase
    end

    // clear is applied before set, so a same-cycle hardware/test set survives a W1C
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_esc_en_q      <= '0;
            r_intr_state    <= '0;
            r_intr_enable   <= '0;
            r_sigint_status <= '0;
            r_rdata         <= '0;
            r_nmi           <= 1'b0;
        end else begin
            r_esc_en_q      <= w_esc_en;
            r_intr_state    <= (r_intr_state & ~w_state_clr) | w_hw_set | w_test_set;
            r_sigint_status <= (r_sigint_status & ~w_sig_clr) | w_sigint;
            if (reg_if.reg_we_i && reg_if.reg_addr_i == ADDR_INTR_ENABLE)
                r_intr_enable <= w_wdata;
            if (reg_if.reg_re_i)
                r_rdata <= w_rd_val;
            r_nmi <= |intr_o;
        end
    end

    assign intr_o             = r_intr_state & r_intr_enable;
    assign esc_en_o           = w_esc_en;
    assign nmi_o              = r_nmi;
    assign reg_if.reg_rdata_o = r_rdata;

endmodule

// File: tb/tb_nmi_gen_multi.sv
// Directed + randomized bench for nmi_gen_multi (N_ESC=4, DW=32) with a register-level reference model.
module tb_nmi_gen_multi;

    logic       clk;
    logic       rst;
    logic [3:0] esc_p, esc_n, resp_p, resp_n, esc_en, intr;
    logic       nmi;

    int         total = 0;
    int         bad   = 0;
    logic [31:0] v;
    logic [31:0] e1;
    logic [31:0] sig_en_exp;
    logic [31:0] data;
    int unsigned ch, addr, op;
    logic [3:0] m_state, m_en, m_sig, m_prev;

    nmi_gen_multi_if #(.DW(32)) bus ();

    nmi_gen_multi #(.N_ESC(4), .DW(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .reg_if   (bus.slave),
        .esc_p_i  (esc_p),
        .esc_n_i  (esc_n),
        .resp_p_o (resp_p),
        .resp_n_o (resp_n),
        .esc_en_o (esc_en),
        .intr_o   (intr),
        .nmi_o    (nmi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_esc(input int unsigned c, input logic [1:0] e);
        esc_p[c] = e[1];
        esc_n[c] = e[0];
    endtask

    task automatic reg_wr(input int unsigned a, input logic [31:0] d);
        bus.reg_we_i    = 1'b1;
        bus.reg_addr_i  = 3'(a);
        bus.reg_wdata_i = d;
        step();
        bus.reg_we_i    = 1'b0;
    endtask

    task automatic reg_rd(input int unsigned a, output logic [31:0] d);
        bus.reg_re_i   = 1'b1;
        bus.reg_addr_i = 3'(a);
        step();
        bus.reg_re_i   = 1'b0;
        d = bus.reg_rdata_o;
    endtask

    initial begin
`ifdef NMI_GEN_SIGINT_ESC_EN
        sig_en_exp = 32'h2;
`else
        sig_en_exp = 32'h0;
`endif
        esc_p = 4'h0; esc_n = 4'hF;
        bus.reg_we_i = 1'b0; bus.reg_re_i = 1'b0;
        bus.reg_addr_i = 3'd0; bus.reg_wdata_i = '0;
        rst = 1'b1;
        step(); step();
        chk("rst_resp_p", 32'(resp_p), 32'h0);
        chk("rst_resp_n", 32'(resp_n), 32'hF);
        chk("rst_esc_en", 32'(esc_en), 32'h0);
        chk("rst_intr", 32'(intr), 32'h0);
        chk("rst_nmi", 32'(nmi), 32'h0);
        chk("rst_rdata", bus.reg_rdata_o, 32'h0);
        rst = 1'b0;
        step();

        // ping on ch0: expect resp 01,10,01,01 and no escalation
        set_esc(0, 2'b10);
        chk("ping_r0", 32'({resp_p[0], resp_n[0]}), 32'h1);
        step();
        chk("ping_r1", 32'({resp_p[0], resp_n[0]}), 32'h2);
        set_esc(0, 2'b01);
        step();
        chk("ping_r2", 32'({resp_p[0], resp_n[0]}), 32'h1);
        step();
        chk("ping_r3", 32'({resp_p[0], resp_n[0]}), 32'h1);
        chk("ping_esc_en", 32'(esc_en), 32'h0);
        reg_rd(0, v);
        chk("ping_state", v, 32'h0);

        // escalation on a random channel
        ch = $urandom_range(0, 3);
        e1 = 32'h1 << ch;
        reg_wr(1, 32'hF);
        set_esc(ch, 2'b10);
        step();
        chk("esc_check_resp", 32'({resp_p[ch], resp_n[ch]}), 32'h2);
        step();
        chk("esc_en_latency", 32'(esc_en), 32'h0);
        chk("esc_resp0", 32'({resp_p[ch], resp_n[ch]}), 32'h1);
        step();
        chk("esc_en_on", 32'(esc_en), e1);
        chk("esc_resp1", 32'({resp_p[ch], resp_n[ch]}), 32'h2);
        step();
        chk("esc_intr", 32'(intr), e1);
        chk("esc_nmi_early", 32'(nmi), 32'h0);
        chk("esc_resp2", 32'({resp_p[ch], resp_n[ch]}), 32'h1);
        step();
        chk("esc_nmi", 32'(nmi), 32'h1);
        step();
        set_esc(ch, 2'b01);
        step();
        step();
        chk("esc_en_off", 32'(esc_en), 32'h0);
        reg_rd(0, v);
        chk("esc_state", v, e1);

        // W1C racing a new ch2 edge
        reg_wr(0, 32'hF);
        reg_rd(0, v);
        chk("w1c_clear", v, 32'h0);
        set_esc(2, 2'b10);
        step(); step(); step();
        chk("race_esc_en", 32'(esc_en), 32'h4);
        reg_wr(0, 32'h4);
        reg_rd(0, v);
        chk("race_set_wins", v, 32'h4);
        reg_rd(4, v);
        chk("esc_active", v, 32'h4);
        reg_wr(0, 32'h4);
        reg_rd(0, v);
        chk("w1c_no_edge", v, 32'h0);
        set_esc(2, 2'b01);
        step(); step();
        chk("race_esc_off", 32'(esc_en), 32'h0);

        // INTR_TEST with enable off then on
        reg_wr(1, 32'h0);
        reg_wr(0, 32'hF);
        reg_wr(2, 32'h9);
        chk("test_intr_off", 32'(intr), 32'h0);
        reg_rd(0, v);
        chk("test_state", v, 32'h9);
        reg_rd(2, v);
        chk("test_reads0", v, 32'h0);
        chk("test_nmi_off", 32'(nmi), 32'h0);
        reg_wr(1, 32'hF);
        chk("test_intr_on", 32'(intr), 32'h9);
        step();
        chk("test_nmi_on", 32'(nmi), 32'h1);

        // same-cycle read and write returns the old value
        bus.reg_re_i = 1'b1; bus.reg_we_i = 1'b1;
        bus.reg_addr_i = 3'd1; bus.reg_wdata_i = 32'h5;
        step();
        bus.reg_re_i = 1'b0; bus.reg_we_i = 1'b0;
        chk("rw_old", bus.reg_rdata_o, 32'hF);
        reg_rd(1, v);
        chk("rw_new", v, 32'h5);
        reg_wr(1, 32'hFFFF_FFFF);
        reg_rd(1, v);
        chk("upper_bits0", v, 32'hF);
        for (int a = 5; a < 8; a++) begin
            reg_wr(a, 32'hFFFF_FFFF);
            reg_rd(a, v);
            chk("unmapped", v, 32'h0);
        end

        // SIGINT on ch1
        reg_wr(0, 32'hF);
        reg_wr(3, 32'hF);
        set_esc(1, 2'b11);
        step();
        chk("sig_resp11", 32'({resp_p[1], resp_n[1]}), 32'h3);
        step();
        chk("sig_resp00", 32'({resp_p[1], resp_n[1]}), 32'h0);
        chk("sig_esc_en", 32'(esc_en), sig_en_exp);
        step();
        chk("sig_resp11b", 32'({resp_p[1], resp_n[1]}), 32'h3);
        set_esc(1, 2'b01);
        step();
        chk("sig_idle", 32'({resp_p[1], resp_n[1]}), 32'h1);
        reg_rd(3, v);
        chk("sig_status", v, 32'h2);
        reg_wr(3, 32'h2);
        reg_rd(3, v);
        chk("sig_w1c", v, 32'h0);

        // reset during ESCRESP
        reg_wr(1, 32'hF);
        set_esc(3, 2'b10);
        step(); step(); step(); step();
        chk("pre_rst_esc_en", 32'(esc_en), 32'h8);
        rst = 1'b1;
        step();
        chk("mid_rst_esc_en", 32'(esc_en), 32'h0);
        chk("mid_rst_resp_p", 32'(resp_p), 32'h0);
        chk("mid_rst_resp_n", 32'(resp_n), 32'hF);
        chk("mid_rst_intr", 32'(intr), 32'h0);
        chk("mid_rst_nmi", 32'(nmi), 32'h0);
        set_esc(3, 2'b01);
        rst = 1'b0;
        step();
        for (int a = 0; a < 5; a++) begin
            reg_rd(a, v);
            chk("post_rst_reg", v, 32'h0);
        end

        // randomized register traffic against the model, escalation lines idle
        m_state = '0; m_en = '0; m_sig = '0;
        step();
        for (int i = 0; i < 80; i++) begin
            m_prev = m_state & m_en;
            op   = $urandom_range(0, 1);
            addr = $urandom_range(0, 7);
            data = $urandom;
            if (op == 0) begin
                reg_wr(addr, data);
                case (addr)
                    0: m_state = m_state & ~data[3:0];
                    1: m_en    = data[3:0];
                    2: m_state = m_state | data[3:0];
                    3: m_sig   = m_sig & ~data[3:0];
                    default: ;
                endcase
            end else begin
                reg_rd(addr, v);
                case (addr)
                    0: chk("rnd_rd_state", v, 32'(m_state));
                    1: chk("rnd_rd_enable", v, 32'(m_en));
                    3: chk("rnd_rd_sig", v, 32'(m_sig));
                    default: chk("rnd_rd_zero", v, 32'h0);
                endcase
            end
            chk("rnd_intr", 32'(intr), 32'(m_state & m_en));
            chk("rnd_nmi", 32'(nmi), 32'(|m_prev));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
